// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying RAM words with a last-beat marker.
interface bram_stream_reader_if #(
  parameter int DW = 8
);
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Sweeps a contiguous RAM address range and streams the read words through a
// 2-entry buffer, absorbing the RAM's one-cycle read latency.
module bram_stream_reader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  bram_stream_reader_if.master m
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW:0]          rem_q, rem_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 last_pend_q, last_pend_d;
  logic [1:0][DW-1:0]   data_q, data_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           occ;
  logic [1:0]           fill;

  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign ram_addr = ptr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = data_q[0];
  assign m.m_last  = (count_q != 2'd0) & last_q[0];

  always_comb begin
    pop  = m.m_valid & m.m_ready;
    push = rd_pend_q;
    // Credit: buffered words plus the read in flight, net of this cycle's pop.
    occ   = 3'({1'b0, count_q}) + 3'({2'b00, rd_pend_q}) - 3'({2'b00, pop});
    issue = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2);
    fill  = count_q - {1'b0, pop};

    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_pend_d   = issue;
    last_pend_d = issue && (rem_q == (AW+1)'(1));
    data_d      = data_q;
    last_d      = last_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      ptr_d = ptr_q + AW'(1);
      rem_d = rem_q - (AW+1)'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = RUN;
            ptr_d   = base_addr;
            rem_d   = length;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (rem_q == (AW+1)'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && last_q[0]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shift-register FIFO: head is slot 0, a push lands after the survivors.
    if (pop) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
    end
    if (push) begin
      if (fill == 2'd0) begin
        data_d[0] = ram_dout;
        last_d[0] = last_pend_q;
      end else begin
        data_d[1] = ram_dout;
        last_d[1] = last_pend_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      data_q      <= '0;
      last_q      <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      assert (!(push && !pop && (count_q == 2'd2)));
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      rd_pend_q   <= rd_pend_d;
      last_pend_q <= last_pend_d;
      data_q      <= data_d;
      last_q      <= last_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 16x8 synchronous-read RAM model.
module tb_bram_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy, done, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];

  bram_stream_reader_if #(.DW(8)) sif ();

  bram_stream_reader #(.AW(4), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .m        (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] beat_data [$];
  logic       beat_last [$];
  int         beat_j [$];
  logic [3:0] addr_log [$];
  logic [7:0] exp_q [$];
  int         done_j;
  int         max_out;
  logic [0:15] pat = 16'b1001011001110010;

  // j counts edges after the start edge; inputs set at iteration j act on edge j+1.
  task automatic run_sweep(input logic [3:0] base, input logic [4:0] len,
                           input bit use_pat, input bit restart);
    logic       stalled = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;
    logic [3:0] prev_addr;
    logic       rdy;
    int         issued = 0;
    beat_data.delete(); beat_last.delete(); beat_j.delete(); addr_log.delete();
    done_j  = -1;
    max_out = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len; sif.m_ready = 1'b1;
    prev_addr = base;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (restart && j == 2) begin
        start = 1'b1; base_addr = 4'd9; length = 5'd3;
      end else begin
        start = 1'b0;
      end
      addr_log.push_back(ram_addr);
      if (j >= 1 && ram_addr != prev_addr) issued++;
      prev_addr = ram_addr;
      if (issued - beat_data.size() > max_out) max_out = issued - beat_data.size();
      if (j == 0 && len != 0) check("busy_after_start", busy, 1);
      if (stalled) begin
        check("stall_valid", sif.m_valid, 1);
        check("stall_data", sif.m_data, held_data);
        check("stall_last", sif.m_last, held_last);
      end
      if (done) begin
        done_j = j;
        check("busy_at_done", busy, 0);
        break;
      end
      rdy = use_pat ? pat[j % 16] : 1'b1;
      sif.m_ready = rdy;
      if (sif.m_valid && rdy) begin
        beat_data.push_back(sif.m_data);
        beat_last.push_back(sif.m_last);
        beat_j.push_back(j);
      end
      stalled   = sif.m_valid && !rdy;
      held_data = sif.m_data;
      held_last = sif.m_last;
    end
    check("done_seen", done_j >= 0, 1);
    check("max_outstanding_le2", max_out <= 2, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("valid_after_done", sif.m_valid, 0);
    sif.m_ready = 1'b1;
  endtask

  task automatic check_beats(input string name);
    check({name, "_count"}, beat_data.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < beat_data.size()) begin
        check($sformatf("%s_data%0d", name, i), beat_data[i], exp_q[i]);
        check($sformatf("%s_last%0d", name, i), beat_last[i], (i == exp_q.size() - 1));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; sif.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", sif.m_valid, 0);
    check("rst_last", sif.m_last, 0);
    check("rst_data", sif.m_data, 8'h00);
    check("rst_addr", ram_addr, 4'd0);
    check("rst_we", ram_we, 0);
    check("rst_din", ram_din, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep, cycle-exact timing.
    run_sweep(4'd0, 5'd3, 1'b0, 1'b0);
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    check_beats("t1");
    if (beat_j.size() == 3) begin
      check("t1_j0", beat_j[0], 2);
      check("t1_j1", beat_j[1], 3);
      check("t1_j2", beat_j[2], 4);
    end
    check("t1_done_j", done_j, 5);
    check("t1_busy_after", busy, 0);

    // Address wrap.
    run_sweep(4'd14, 5'd4, 1'b0, 1'b0);
    exp_q = '{8'h1E, 8'h1F, 8'hAA, 8'hBB};
    check_beats("t2");
    check("t2_addr0", addr_log[0], 4'd14);
    check("t2_addr1", addr_log[1], 4'd15);
    check("t2_addr2", addr_log[2], 4'd0);
    check("t2_addr3", addr_log[3], 4'd1);
    check("t2_done_j", done_j, 6);

    // Backpressure pattern.
    run_sweep(4'd0, 5'd6, 1'b1, 1'b0);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'h13, 8'h14, 8'h15};
    check_beats("t3");

    // Zero length: pointer stays where the previous sweep left it (6).
    run_sweep(4'd7, 5'd0, 1'b0, 1'b0);
    check("t4_done_j", done_j, 0);
    check("t4_beats", beat_data.size(), 0);
    check("t4_addr", addr_log[0], 4'd6);

    // Start while busy is ignored.
    run_sweep(4'd0, 5'd8, 1'b0, 1'b1);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    check_beats("t5");
    check("t5_done_j", done_j, 10);

    // Full-depth sweep with wrap.
    run_sweep(4'd5, 5'd16, 1'b0, 1'b0);
    exp_q = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C,
              8'h1D, 8'h1E, 8'h1F, 8'hAA, 8'hBB, 8'hCC, 8'h13, 8'h14};
    check_beats("t6");
    check("t6_done_j", done_j, 18);

    // Reset mid-sweep with the buffer full.
    @(negedge clk);
    start = 1'b1; base_addr = 4'd0; length = 5'd8; sif.m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_full_valid", sif.m_valid, 1);
    check("t7_full_data", sif.m_data, 8'hAA);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t7_valid", sif.m_valid, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_last", sif.m_last, 0);
    check("t7_data", sif.m_data, 8'h00);
    sif.m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t7_no_done", done, 0);
    end
    run_sweep(4'd2, 5'd1, 1'b0, 1'b0);
    exp_q = '{8'hCC};
    check_beats("t7b");
    check("t7b_done_j", done_j, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
